// File: rtl/seven_seg_scan_ctrl_if.sv
// Display-word update channel between the ALU result register and the scan controller.
// The producer side drives data/valid; the controller answers with ready.
interface seven_seg_scan_ctrl_if;
    logic [15:0] upd_data;
    logic        upd_valid;
    logic        upd_ready;

    modport master (output upd_data, output upd_valid, input upd_ready);
    modport slave  (input upd_data, input upd_valid, output upd_ready);
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller: prescaled refresh, dead-time blanking,
// leading-zero suppression and tear-free display-word updates latched at frame start.
module seven_seg_scan_ctrl #(
    parameter int unsigned PRESC       = 1000,
    parameter int unsigned ON_TICKS    = 4,
    parameter int unsigned BLANK_TICKS = 1
) (
    input  logic                        clk,
    input  logic                        res,
    input  logic                        en,
    input  logic                        lz_en,
    seven_seg_scan_ctrl_if.slave        upd,
    output logic [3:0]                  anodes,
    output logic [3:0]                  nibble,
    output logic [1:0]                  digit_idx,
    output logic                        frame_st
);

    localparam int unsigned PW   = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int unsigned TMAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {ST_OFF, ST_BLANK, ST_SHOW} state_t;

    state_t        state_q, state_d;
    logic [1:0]    digit_q, digit_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_full_q, pend_full_d;
    logic [3:0]    anodes_d, nibble_d;
    logic          tick, fstart, xfer, lit;

    assign upd.upd_ready = ~pend_full_q;
    assign digit_idx     = digit_q;

    always_comb begin
        tick   = en && (state_q != ST_OFF) && (pcnt_q == PW'(PRESC - 1));
        pcnt_d = pcnt_q;
        if (!en || state_q == ST_OFF || tick) pcnt_d = '0;
        else                                  pcnt_d = pcnt_q + 1'b1;

        state_d = state_q;
        digit_d = digit_q;
        tcnt_d  = tcnt_q;
        fstart  = 1'b0;
        if (!en) begin
            state_d = ST_OFF;
            digit_d = '0;
            tcnt_d  = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_BLANK;
                    digit_d = '0;
                    tcnt_d  = '0;
                    fstart  = 1'b1;
                end
                ST_BLANK: if (tick) begin
                    if (tcnt_q == TW'(BLANK_TICKS - 1)) begin
                        state_d = ST_SHOW;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                ST_SHOW: if (tick) begin
                    if (tcnt_q == TW'(ON_TICKS - 1)) begin
                        state_d = ST_BLANK;
                        tcnt_d  = '0;
                        digit_d = digit_q + 2'd1;
                        fstart  = (digit_q == 2'd3);
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    digit_d = '0;
                    tcnt_d  = '0;
                end
            endcase
        end
    end

    // Copy uses the pending word held before this edge, so a same-edge transfer waits a frame.
    always_comb begin
        xfer        = upd.upd_valid && !pend_full_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (fstart && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (xfer) begin
            pend_d      = upd.upd_data;
            pend_full_d = 1'b1;
        end
    end

    always_comb begin
        lit      = (digit_d == 2'd0) || !lz_en || ((disp_d >> {digit_d, 2'b00}) != '0);
        nibble_d = (state_d == ST_OFF) ? 4'h0 : disp_d[{digit_d, 2'b00} +: 4];
        anodes_d = (state_d == ST_SHOW && lit) ? (4'b0001 << digit_d) : 4'h0;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= ST_BLANK;
            digit_q     <= '0;
            tcnt_q      <= '0;
            pcnt_q      <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            anodes      <= '0;
            nibble      <= '0;
            frame_st    <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_q     <= digit_d;
            tcnt_q      <= tcnt_d;
            pcnt_q      <= pcnt_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            anodes      <= anodes_d;
            nibble      <= nibble_d;
            frame_st    <= fstart;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with PRESC=2, ON_TICKS=3, BLANK_TICKS=1 (32-clock frame).
module tb_seven_seg_scan_ctrl;

    localparam int unsigned PRESC       = 2;
    localparam int unsigned ON_TICKS    = 3;
    localparam int unsigned BLANK_TICKS = 1;

    logic       clk = 1'b0;
    logic       res, en, lz_en;
    logic [3:0] anodes, nibble;
    logic [1:0] digit_idx;
    logic       frame_st;

    seven_seg_scan_ctrl_if upd_if ();

    seven_seg_scan_ctrl #(
        .PRESC       (PRESC),
        .ON_TICKS    (ON_TICKS),
        .BLANK_TICKS (BLANK_TICKS)
    ) dut (
        .clk       (clk),
        .res       (res),
        .en        (en),
        .lz_en     (lz_en),
        .upd       (upd_if.slave),
        .anodes    (anodes),
        .nibble    (nibble),
        .digit_idx (digit_idx),
        .frame_st  (frame_st)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference: displayed word, pending word and its occupancy.
    logic [15:0] disp_m, pend_m;
    logic        pend_full_m;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with en low, let the FSM fall to OFF, then raise en so the next edge is a frame start.
    task automatic do_reset();
        res = 1'b1;
        step();
        check("rst_anodes", 16'(anodes), 16'h0);
        check("rst_nibble", 16'(nibble), 16'h0);
        check("rst_digit", 16'(digit_idx), 16'h0);
        check("rst_frame_st", 16'(frame_st), 16'h0);
        check("rst_ready", 16'(upd_if.upd_ready), 16'h1);
        res = 1'b0;
        en  = 1'b0;
        step();
        en  = 1'b1;
        step();
        disp_m      = 16'h0;
        pend_m      = 16'h0;
        pend_full_m = 1'b0;
    endtask

    // Called right after a frame-start edge; checks ncyc clocks and optionally pushes a word.
    task automatic run_frame(input logic lz, input int push_at, input logic [15:0] word,
                             input int ncyc);
        int         d, pos;
        logic       lit, xfer;
        logic [3:0] exp_an, exp_nib;
        lz_en = lz;
        for (int i = 0; i < ncyc; i++) begin
            d       = i / 8;
            pos     = i % 8;
            exp_nib = 4'(disp_m >> (4 * d));
            lit     = !lz || (d == 0) || ((disp_m >> (4 * d)) != 16'h0);
            exp_an  = (pos >= 2 && lit) ? 4'(1 << d) : 4'h0;
            check("anodes", 16'(anodes), 16'(exp_an));
            check("nibble", 16'(nibble), 16'(exp_nib));
            check("digit_idx", 16'(digit_idx), 16'(d));
            check("frame_st", 16'(frame_st), 16'(i == 0));
            check("upd_ready", 16'(upd_if.upd_ready), 16'(!pend_full_m));
            if (i == push_at) begin
                upd_if.upd_valid = 1'b1;
                upd_if.upd_data  = word;
            end
            xfer = upd_if.upd_valid && !pend_full_m;
            if (i == 31 && pend_full_m) begin
                disp_m      = pend_m;
                pend_full_m = 1'b0;
            end
            if (xfer) begin
                pend_m      = upd_if.upd_data;
                pend_full_m = 1'b1;
            end
            step();
            upd_if.upd_valid = 1'b0;
            upd_if.upd_data  = 16'hDEAD;
        end
    endtask

    initial begin
        res              = 1'b1;
        en               = 1'b0;
        lz_en            = 1'b0;
        upd_if.upd_valid = 1'b0;
        upd_if.upd_data  = 16'h0;
        step();
        step();
        do_reset();

        // Blank display, push 1234 mid-frame; it appears only in the next frame.
        run_frame(1'b0, 10, 16'h1234, 32);
        run_frame(1'b0, 5, 16'h00A0, 32);
        // 00A0 with leading-zero suppression, then without; push lands in the frame_st cycle.
        run_frame(1'b1, -1, 16'h0, 32);
        run_frame(1'b0, 0, 16'hBEEF, 32);

        // Stop scanning during SHOW of digit 2.
        run_frame(1'b0, -1, 16'h0, 19);
        check("show_d2_anodes", 16'(anodes), 16'h4);
        check("show_d2_nibble", 16'(nibble), 16'hE);
        en = 1'b0;
        step();
        check("off_anodes", 16'(anodes), 16'h0);
        check("off_nibble", 16'(nibble), 16'h0);
        check("off_frame_st", 16'(frame_st), 16'h0);
        upd_if.upd_valid = 1'b1;
        upd_if.upd_data  = 16'h5678;
        step();
        upd_if.upd_valid = 1'b0;
        check("off_ready", 16'(upd_if.upd_ready), 16'h0);
        step();
        step();
        check("off_anodes_hold", 16'(anodes), 16'h0);
        en = 1'b1;
        step();
        disp_m      = 16'h5678;
        pend_full_m = 1'b0;
        run_frame(1'b0, -1, 16'h0, 32);

        // Reset during SHOW digit 1 with a word pending.
        run_frame(1'b0, 3, 16'h9ABC, 10);
        check("pre_rst_anodes", 16'(anodes), 16'h2);
        check("pre_rst_ready", 16'(upd_if.upd_ready), 16'h0);
        do_reset();
        run_frame(1'b0, -1, 16'h0, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
